// File: rtl/io_bridge_pkg.sv
// Shared constants and bus-slicing helper for the FP processor I/O bridge.
package io_bridge_pkg;
  localparam int NBMANT_DEF = 16;
  localparam int NBEXPO_DEF = 6;
  localparam int FDEPTH_DEF = 4;
  localparam int NBW        = NBMANT_DEF + NBEXPO_DEF + 1;
  localparam int FPTRW      = $clog2(FDEPTH_DEF);

  // LSB position of channel k inside a packed multi-channel bus of w-bit words.
  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction
endpackage

// File: rtl/io_bridge_fl_fifo.sv
// Small synchronous FIFO with a combinational head; push-when-full and pop-when-empty are ignored.
module fifo_fl
  import io_bridge_pkg::*;
#(
  parameter int NBDATA = NBW,
  parameter int DEPTH  = FDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NBDATA-1:0] din,
  input  logic              pop,
  output logic [NBDATA-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(DEPTH);

  logic [NBDATA-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  // Full/empty come from registered state only, so a pop never frees room for a same-cycle push.
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/io_bridge_fl.sv
// Peripheral-side responder for the FP processor I/O port: FIFO-buffered valid/ready channels.
// Define IO_ITR_EN to build the input-arrival interrupt; otherwise itr is tied low.
module io_bridge_fl
  import io_bridge_pkg::*;
#(
  parameter int NBMANT = NBMANT_DEF,
  parameter int NBEXPO = NBEXPO_DEF,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic [NBMANT+NBEXPO:0]                 io_in,
  input  logic [NBMANT+NBEXPO:0]                 io_out,
  input  logic [$clog2(NUIOIN)-1:0]              addr_in,
  input  logic [$clog2(NUIOOU)-1:0]              addr_out,
  input  logic                                   req_in,
  input  logic                                   out_en,
  output logic                                   itr,
  input  logic [NUIOIN*(NBMANT+NBEXPO+1)-1:0]    in_data,
  input  logic [NUIOIN-1:0]                      in_valid,
  output logic [NUIOIN-1:0]                      in_ready,
  output logic [NUIOOU*(NBMANT+NBEXPO+1)-1:0]    out_data,
  output logic [NUIOOU-1:0]                      out_valid,
  input  logic [NUIOOU-1:0]                      out_ready,
  output logic [NUIOIN-1:0]                      err_unf,
  output logic [NUIOOU-1:0]                      err_ovf,
  input  logic                                   clr_err
);
  localparam int WW  = NBMANT + NBEXPO + 1;
  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);

  logic [WW-1:0]     in_head [NUIOIN];
  logic [WW-1:0]     hold_q  [NUIOIN];
  logic [WW-1:0]     hold_d  [NUIOIN];
  logic [NUIOIN-1:0] in_empty, in_full, in_push, in_pop;
  logic [NUIOOU-1:0] out_empty, out_full, out_push, out_pop;
  logic [NUIOIN-1:0] err_unf_q, err_unf_d;
  logic [NUIOOU-1:0] err_ovf_q, err_ovf_d;
  logic              rd_ok, wr_ok;

  assign rd_ok   = int'(addr_in) < NUIOIN;
  assign wr_ok   = int'(addr_out) < NUIOOU;
  assign err_unf = err_unf_q;
  assign err_ovf = err_ovf_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUIOIN; gi++) begin : g_in
      localparam logic [AIW-1:0] CH = AIW'(gi);
      assign in_push[gi]  = in_valid[gi] & ~in_full[gi];
      assign in_ready[gi] = ~in_full[gi];
      assign in_pop[gi]   = req_in & rd_ok & (addr_in == CH) & ~in_empty[gi];
      fifo_fl #(.NBDATA(WW), .DEPTH(FDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push[gi]),
        .din   (in_data[chan_lsb(gi, WW) +: WW]),
        .pop   (in_pop[gi]),
        .dout  (in_head[gi]),
        .empty (in_empty[gi]),
        .full  (in_full[gi])
      );
    end

    for (gi = 0; gi < NUIOOU; gi++) begin : g_out
      localparam logic [AOW-1:0] CH = AOW'(gi);
      assign out_push[gi]  = out_en & wr_ok & (addr_out == CH);
      assign out_pop[gi]   = ~out_empty[gi] & out_ready[gi];
      assign out_valid[gi] = ~out_empty[gi];
      fifo_fl #(.NBDATA(WW), .DEPTH(FDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_push[gi]),
        .din   (io_out),
        .pop   (out_pop[gi]),
        .dout  (out_data[chan_lsb(gi, WW) +: WW]),
        .empty (out_empty[gi]),
        .full  (out_full[gi])
      );
    end
  endgenerate

  // Read path: live head when data is queued, otherwise replay the last word popped.
  always_comb begin
    io_in     = '0;
    err_unf_d = clr_err ? '0 : err_unf_q;
    err_ovf_d = clr_err ? '0 : err_ovf_q;
    for (int k = 0; k < NUIOIN; k++) begin
      hold_d[k] = in_pop[k] ? in_head[k] : hold_q[k];
      if (rd_ok && addr_in == AIW'(k)) begin
        io_in = in_empty[k] ? hold_q[k] : in_head[k];
        if (req_in && in_empty[k]) err_unf_d[k] = 1'b1;
      end
    end
    for (int k = 0; k < NUIOOU; k++) begin
      if (out_push[k] && out_full[k]) err_ovf_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUIOIN; k++) hold_q[k] <= '0;
      err_unf_q <= '0;
      err_ovf_q <= '0;
    end else begin
      for (int k = 0; k < NUIOIN; k++) hold_q[k] <= hold_d[k];
      err_unf_q <= err_unf_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef IO_ITR_EN
  logic itr_q, itr_d;
  // A push into an empty FIFO is exactly the empty -> non-empty transition (no pop can hit an empty FIFO).
  assign itr_d = |(in_empty & in_push);
  always_ff @(posedge clk) begin
    if (rst) itr_q <= 1'b0;
    else     itr_q <= itr_d;
  end
  assign itr = itr_q;
`else
  assign itr = 1'b0;
`endif
endmodule

// File: tb/tb_io_bridge_fl.sv
// Directed scoreboard bench for io_bridge_fl: reads and output-channel drains are checked by a monitor.
module tb_io_bridge_fl;
  localparam int NBW = 23;
  localparam int NI  = 2;
  localparam int NO  = 2;
`ifdef IO_ITR_EN
  localparam logic EXP_PULSE = 1'b1;
`else
  localparam logic EXP_PULSE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NBW-1:0]    io_in, io_out;
  logic [0:0]        addr_in, addr_out;
  logic              req_in, out_en, itr, clr_err;
  logic [NI*NBW-1:0] in_data;
  logic [NI-1:0]     in_valid, in_ready, err_unf;
  logic [NO*NBW-1:0] out_data;
  logic [NO-1:0]     out_valid, out_ready, err_ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [NBW-1:0] rd_q [$];
  logic [NBW-1:0] out_q [NO][$];

  logic [NBW-1:0] w1 [4] = '{23'h000111, 23'h222222, 23'h333333, 23'h444444};
  logic [NBW-1:0] ow [5] = '{23'h0A0001, 23'h0A0002, 23'h0A0003, 23'h0A0004, 23'h0A0005};

  always #5 clk = ~clk;

  io_bridge_fl dut (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out),
    .addr_in(addr_in), .addr_out(addr_out), .req_in(req_in), .out_en(out_en),
    .itr(itr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_unf(err_unf), .err_ovf(err_ovf), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && req_in) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_unexpected: got %0h expected none", io_in);
      end else begin
        check("io_in", 32'(io_in), 32'(rd_q.pop_front()));
      end
    end
    for (int j = 0; j < NO; j++) begin
      if (!rst && out_valid[j] && out_ready[j]) begin
        if (out_q[j].size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL out%0d_unexpected: got %0h expected none", j, out_data[j*NBW +: NBW]);
        end else begin
          check($sformatf("out%0d_data", j), 32'(out_data[j*NBW +: NBW]), 32'(out_q[j].pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; io_out = '0; addr_in = '0; addr_out = '0; req_in = 1'b0;
    out_en = 1'b0; clr_err = 1'b0; in_data = '0; in_valid = '0; out_ready = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'h3);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_io_in", 32'(io_in), 32'h0);
    check("rst_itr", 32'(itr), 32'h0);

    // Single word on ch0, read it, then underflow.
    in_data[0 +: NBW] = 23'h1A2B3C; in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    check("itr_pulse", 32'(itr), 32'(EXP_PULSE));
    step();
    check("itr_low", 32'(itr), 32'h0);
    addr_in = 1'b0; req_in = 1'b1; rd_q.push_back(23'h1A2B3C);
    step();
    req_in = 1'b0;
    check("unf_clear", 32'(err_unf), 32'h0);
    req_in = 1'b1; rd_q.push_back(23'h1A2B3C);
    step();
    req_in = 1'b0;
    check("unf_set", 32'(err_unf), 32'h1);

    // Fill ch1, attempt a fifth push, then read back in order.
    for (int i = 0; i < 4; i++) begin
      in_data[NBW +: NBW] = w1[i]; in_valid = 2'b10;
      step();
      if (i == 0) check("itr_ch1", 32'(itr), 32'(EXP_PULSE));
    end
    check("ch1_full", 32'(in_ready), 32'h1);
    in_data[NBW +: NBW] = 23'h555555;
    step();
    in_valid = 2'b00;
    check("ch1_still_full", 32'(in_ready), 32'h1);
    addr_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_in = 1'b1; rd_q.push_back(w1[i]);
      step();
    end
    req_in = 1'b0;
    check("ch1_drained", 32'(in_ready), 32'h3);

    // Five writes into out ch1 with no consumer: fifth is dropped.
    addr_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_en = 1'b1; io_out = ow[i];
      if (i < 4) out_q[1].push_back(ow[i]);
      step();
      if (i == 0) check("out_lat1", 32'(out_valid), 32'h2);
    end
    out_en = 1'b0;
    check("ovf_set", 32'(err_ovf), 32'h2);
    out_ready = 2'b11;
    for (int c = 0; c < 20 && out_valid != '0; c++) step();
    check("out_drained", 32'(out_valid), 32'h0);
    out_ready = 2'b00;

    // Same-cycle push and read on ch0 with one word queued.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_all", 32'({err_unf, err_ovf}), 32'h0);
    addr_in = 1'b0; in_data[0 +: NBW] = 23'h00AAAA; in_valid = 2'b01;
    step();
    in_data[0 +: NBW] = 23'h00BBBB; req_in = 1'b1; rd_q.push_back(23'h00AAAA);
    step();
    in_valid = 2'b00; rd_q.push_back(23'h00BBBB);
    step();
    req_in = 1'b0;
    check("pushpop_no_unf", 32'(err_unf), 32'h0);
    req_in = 1'b1; rd_q.push_back(23'h00BBBB);
    step();
    req_in = 1'b0;
    check("pushpop_cnt1", 32'(err_unf), 32'h1);

    // Reset with words queued everywhere.
    addr_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {23'h010000 + 23'(i), 23'h020000 + 23'(i)}; in_valid = 2'b11;
      out_en = (i < 2); io_out = 23'h030000 + 23'(i);
      step();
    end
    in_valid = 2'b00; out_en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_in_ready", 32'(in_ready), 32'h3);
    check("rst2_out_valid", 32'(out_valid), 32'h0);
    check("rst2_flags", 32'({err_unf, err_ovf}), 32'h0);
    check("rst2_io_in", 32'(io_in), 32'h0);
    check("rst2_itr", 32'(itr), 32'h0);
    addr_in = 1'b0; req_in = 1'b1; rd_q.push_back('0);
    step();
    check("rst2_empty", 32'(err_unf), 32'h1);
    addr_in = 1'b1; clr_err = 1'b1; rd_q.push_back('0);
    step();
    req_in = 1'b0; clr_err = 1'b0;
    check("clr_vs_set", 32'(err_unf), 32'h2);

    step(); step();
    check("rd_q_empty", 32'(rd_q.size()), 32'h0);
    check("out_q_empty", 32'(out_q[0].size() + out_q[1].size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
